saph_fpu_cmp: RTL and testbench
===============================

# saph_fpu_cmp

Fixed-latency, fully pipelined floating-point responder for the FPU end of the `saph_fpi` interface. It accepts one request per cycle from a GPU or from the FPU multiplexer and implements the four non-arithmetic ops: min, max, sign-inject and less-than. Each result is returned exactly `latency` cycles after acceptance. It sits directly behind the FPU multiplexer, or alone on a single-GPU build.

## Interface
- `latency`, default 2: pipeline depth in cycles from accepted request to `q_trig`. Must be ≥1 and must equal `fpu.latency`; a mismatch raises `$error` at elaboration.
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous and active-high.
- `fpu`  `saph_fpi.FPU` modport, containing:
  - `d_trig`  in  1  request valid.
  - `d_ready`  out  1  request may be accepted.
  - `d_lhs`  in  `float` (32-bit binary32)  left operand.
  - `d_rhs`  in  `float`  right operand.
  - `d_mode`  in  2  operation select.
  - `q_trig`  out  1  result valid, single-cycle pulse.
  - `q_res`  out  `float`  result.
  - `has_modes`  out  interface width  constant all-ones; all modes are implemented.
- `inflight`  out  `$clog2(latency+1)`  number of accepted requests not yet returned (debug/perf).

## Operation
- Acceptance: a request is accepted on a rising edge where `d_trig && d_ready`. `d_ready = !rst`, so there is no backpressure outside reset.
- Modes:
  - 0 = min; 1 = max.
  - 2 = sign-inject: `{rhs[31], lhs[30:0]}`.
  - 3 = lt: `0x3f800000` (1.0) if lhs < rhs, else `0x00000000`.
- NaN is any value with exp = 0xff and mantissa ≠ 0; quiet and signalling NaNs are treated alike.
- min/max rules:
  - Exactly one operand NaN: return the other operand unchanged.
  - Both operands NaN: return canonical NaN `0x7fc00000`.
  - Signed zeros: −0 < +0, so min(+0,−0) = `0x80000000` and max(+0,−0) = `0x00000000`.
  - Ordering is by sign-magnitude compare. Denormals compare by raw bits; no flushing.
- lt rules:
  - Any NaN operand gives 0.
  - −0 and +0 compare equal, so lt gives 0.
- Sign-inject passes NaN payloads through untouched.
- Structure:
  - Stage 1 registers the computed result and a valid bit.
  - Stages 2..`latency` form a shift register of {valid, result}.
  - `q_trig` is the valid bit of the last stage.
  - `q_res` is that stage's result ANDed with `q_trig`, so it reads 0 when idle. This keeps OR-combining muxes safe.
- `inflight` update per cycle:
  - +1 on accept, −1 on `q_trig`.
  - Both in the same cycle: unchanged.
  - Never exceeds `latency`.
- `d_lhs`, `d_rhs` and `d_mode` are don't-care when `d_trig` is low.

## Timing
- Request accepted at edge N gives `q_trig` = 1 and `q_res` valid during the cycle after edge N+`latency`−1, i.e. `latency` cycles after the accepting edge.
- Back-to-back requests give back-to-back results with no bubbles, in order.
- Throughput is 1 per cycle; no internal state machine beyond pipeline valid bits.
- Reset values:
  - all stage valid bits 0
  - `q_trig` 0, `q_res` 0
  - `inflight` 0
  - `d_ready` 0 during any cycle with `rst` high
  - `has_modes` all-ones (constant)
- Reset mid-operation: all in-flight requests are dropped and no `q_trig` is produced for them. A request presented in the same cycle as `rst` is not accepted.
- First cycle after `rst` deasserts: `d_ready` = 1 and a request is accepted normally.
- `latency` = 1: stage 1 drives the outputs directly; the shift register is empty.

## Test plan
- latency=2, mode 0, lhs=`0x40000000` (2.0), rhs=`0xbf800000` (−1.0), `d_trig` one cycle -> `q_trig` exactly 2 cycles later for 1 cycle, `q_res`=`0xbf800000`; `q_res`=0 in all other cycles.
- Back-to-back stream of 8 requests cycling modes 0..3 with known operands -> 8 consecutive `q_trig` pulses in order with matching results; `inflight` rises to 2 and stays at 2 while streaming.
- NaN/zero corners:
  - max(`0x7fc00001`, `0x3f800000`) -> `0x3f800000`
  - min(NaN, NaN) -> `0x7fc00000`
  - min(`0x00000000`, `0x80000000`) -> `0x80000000`
  - lt(`0x80000000`, `0x00000000`) -> 0
  - lt(NaN, 1.0) -> 0
  - lt(1.0, 2.0) -> `0x3f800000`
- Sign-inject: lhs=`0x7f812345`, rhs=`0x80000000` -> `0xff812345`.
- Reset mid-flight: issue 2 requests, assert `rst` for 1 cycle the next cycle -> no `q_trig` ever appears for those requests; `inflight`=0 and `d_ready`=0 during reset; a request issued on the first post-reset cycle returns normally after `latency` cycles.
- Parameter sweep latency ∈ {1,3,5} with random traffic against a reference model -> per-request latency is exactly `latency`, and `inflight` always equals outstanding count and stays ≤ `latency`.

Source files
------------

// File: rtl/saph_fpu_cmp.sv
// Fixed-latency pipelined FP compare unit: min, max, sign-inject, less-than.
// Results appear exactly `latency` cycles after acceptance; no backpressure.
module saph_fpu_cmp #(
  parameter int latency = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               d_trig,
  output logic                               d_ready,
  input  logic [31:0]                        d_lhs,
  input  logic [31:0]                        d_rhs,
  input  logic [1:0]                         d_mode,
  output logic                               q_trig,
  output logic [31:0]                        q_res,
  output logic [3:0]                         has_modes,
  output logic [$clog2(latency+1)-1:0]       inflight
);

  localparam int IW = $clog2(latency + 1);
  localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;
  localparam logic [31:0] ONE       = 32'h3f80_0000;

  if (latency < 1) begin : g_bad_latency
    $error("saph_fpu_cmp: latency must be >= 1");
  end

  logic        accept;
  logic        lnan, rnan, both_zero, key_lt;
  logic [31:0] lkey, rkey, res_c;

  assign d_ready   = !rst;
  assign accept    = d_trig && d_ready;
  assign has_modes = '1;

  // Map sign-magnitude onto an unsigned total order: negatives flipped below
  // positives, so -0 sorts just under +0.
  always_comb begin
    lnan      = (&d_lhs[30:23]) && (|d_lhs[22:0]);
    rnan      = (&d_rhs[30:23]) && (|d_rhs[22:0]);
    lkey      = d_lhs[31] ? ~d_lhs : {1'b1, d_lhs[30:0]};
    rkey      = d_rhs[31] ? ~d_rhs : {1'b1, d_rhs[30:0]};
    key_lt    = lkey < rkey;
    both_zero = ~|d_lhs[30:0] && ~|d_rhs[30:0];
    res_c     = '0;
    case (d_mode)
      2'd0, 2'd1: begin
        if (lnan && rnan)      res_c = CANON_NAN;
        else if (lnan)         res_c = d_rhs;
        else if (rnan)         res_c = d_lhs;
        else if (key_lt ^ d_mode[0]) res_c = d_lhs;
        else                   res_c = d_rhs;
      end
      2'd2:    res_c = {d_rhs[31], d_lhs[30:0]};
      default: res_c = (!lnan && !rnan && !both_zero && key_lt) ? ONE : 32'h0;
    endcase
  end

  logic [latency:1] vld_pipe;
  logic [31:0]      res_pipe [latency:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      for (int i = 2; i <= latency; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Data path needs no reset: the output is gated by the valid bit.
  always_ff @(posedge clk) begin
    res_pipe[1] <= res_c;
    for (int i = 2; i <= latency; i++) res_pipe[i] <= res_pipe[i-1];
  end

  assign q_trig = vld_pipe[latency];
  assign q_res  = res_pipe[latency] & {32{q_trig}};

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, q_trig})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_saph_fpu_cmp.sv
// Bench for saph_fpu_cmp: four instances (latency 1,2,3,5) share one stimulus
// stream; a value-level model predicts every output on every cycle.
module tb_saph_fpu_cmp;

  localparam int NDUT = 4;
  localparam int LATS [NDUT] = '{1, 2, 3, 5};

  logic        clk;
  logic        rst;
  logic        d_trig;
  logic [31:0] d_lhs, d_rhs;
  logic [1:0]  d_mode;

  logic        rdy_a   [NDUT];
  logic        qt_a    [NDUT];
  logic [31:0] qr_a    [NDUT];
  logic [3:0]  hm_a    [NDUT];
  int          inf_a   [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = LATS[g];
    logic [$clog2(L+1)-1:0] infl;
    saph_fpu_cmp #(.latency(L)) dut (
      .clk(clk), .rst(rst), .d_trig(d_trig), .d_ready(rdy_a[g]),
      .d_lhs(d_lhs), .d_rhs(d_rhs), .d_mode(d_mode),
      .q_trig(qt_a[g]), .q_res(qr_a[g]), .has_modes(hm_a[g]), .inflight(infl)
    );
    assign inf_a[g] = int'(infl);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: operands as signed integers on the sign-magnitude value line.
  function automatic logic [31:0] ref_op(logic [1:0] m, logic [31:0] a, logic [31:0] b);
    bit     na, nb, pick_a_min;
    longint va, vb;
    na = (a[30:23] == 8'hff) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hff) && (b[22:0] != 0);
    va = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    vb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    if (m == 2) return {b[31], a[30:0]};
    if (m == 3) return (!na && !nb && va < vb) ? 32'h3f800000 : 32'h0;
    if (na && nb) return 32'h7fc00000;
    if (na) return b;
    if (nb) return a;
    pick_a_min = (va < vb) || (va == vb && a[31]);
    if (m == 0) return pick_a_min ? a : b;
    return pick_a_min ? b : a;
  endfunction

  // Edge history: accepted?, result, reset-at-edge.
  bit          acc  [0:4095];
  bit          rat  [0:4095];
  logic [31:0] rres [0:4095];
  int          cyc = 0;

  function automatic void expect_for(int L, int c, output bit t, output logic [31:0] r,
                                     output int inf);
    bit dropped;
    t = 0; r = 0; inf = 0;
    for (int e = c - L + 1; e <= c; e++) begin
      if (e >= 0 && acc[e]) begin
        dropped = 0;
        for (int k = e + 1; k <= c; k++) if (rat[k]) dropped = 1;
        if (!dropped) begin
          inf++;
          if (e == c - L + 1) begin t = 1; r = rres[e]; end
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    bit          et;
    logic [31:0] er;
    int          ei;
    acc[cyc]  = d_trig && !rst;
    rat[cyc]  = rst;
    rres[cyc] = ref_op(d_mode, d_lhs, d_rhs);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      expect_for(LATS[g], cyc, et, er, ei);
      chk($sformatf("q_trig L%0d", LATS[g]), {31'b0, qt_a[g]}, {31'b0, et});
      chk($sformatf("q_res L%0d", LATS[g]), qr_a[g], er);
      chk($sformatf("inflight L%0d", LATS[g]), inf_a[g], ei);
      chk($sformatf("d_ready L%0d", LATS[g]), {31'b0, rdy_a[g]}, {31'b0, !rst});
      if (inf_a[g] > LATS[g]) chk("inflight bound", inf_a[g], LATS[g]);
    end
    cyc++;
  end

  task automatic drive(bit t, logic [1:0] m, logic [31:0] a, logic [31:0] b);
    d_trig = t;
    d_mode = t ? m : 2'($urandom);
    d_lhs  = t ? a : $urandom;
    d_rhs  = t ? b : $urandom;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  logic [31:0] pool [12] = '{32'h40000000, 32'hbf800000, 32'h3f800000, 32'h00000000,
                             32'h80000000, 32'h7fc00001, 32'hff800001, 32'h00000001,
                             32'h80000001, 32'h7f800000, 32'hff800000, 32'h7f812345};
  logic [31:0] sa [8] = '{32'h40000000, 32'hc0400000, 32'h00000005, 32'h7f812345,
                          32'hbf800000, 32'h3f800000, 32'h80000000, 32'h40400000};
  logic [31:0] sb [8] = '{32'hbf800000, 32'hc0000000, 32'h80000001, 32'h80000000,
                          32'hbf000000, 32'h7fc00000, 32'h3f800000, 32'h40000000};

  initial begin
    rst = 1'b1; d_trig = 1'b0; d_mode = 0; d_lhs = 0; d_rhs = 0;

    // Model pins, computed by hand.
    chk("pin min(2,-1)",    ref_op(0, 32'h40000000, 32'hbf800000), 32'hbf800000);
    chk("pin max nan,1",    ref_op(1, 32'h7fc00001, 32'h3f800000), 32'h3f800000);
    chk("pin min nan,nan",  ref_op(0, 32'h7fc00001, 32'hff800001), 32'h7fc00000);
    chk("pin min +0,-0",    ref_op(0, 32'h00000000, 32'h80000000), 32'h80000000);
    chk("pin max +0,-0",    ref_op(1, 32'h00000000, 32'h80000000), 32'h00000000);
    chk("pin lt -0,+0",     ref_op(3, 32'h80000000, 32'h00000000), 32'h0);
    chk("pin lt 1,2",       ref_op(3, 32'h3f800000, 32'h40000000), 32'h3f800000);
    chk("pin sgnj",         ref_op(2, 32'h7f812345, 32'h80000000), 32'hff812345);

    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) chk("has_modes", {28'b0, hm_a[g]}, 32'hf);
    rst = 1'b0;

    // Single request, latency-2 instance checked literally.
    drive(1, 0, 32'h40000000, 32'hbf800000);
    chk("lit L1 q_res", qr_a[0], 32'hbf800000);
    chk("lit L2 idle q_res", qr_a[1], 32'h0);
    drive(0, 0, 0, 0);
    chk("lit L2 q_trig", {31'b0, qt_a[1]}, 32'h1);
    chk("lit L2 q_res", qr_a[1], 32'hbf800000);
    drive(0, 0, 0, 0);
    chk("lit L2 after q_trig", {31'b0, qt_a[1]}, 32'h0);
    chk("lit L2 after q_res", qr_a[1], 32'h0);
    idle(4);

    // Back-to-back stream cycling modes.
    for (int i = 0; i < 8; i++) drive(1, 2'(i), sa[i], sb[i]);
    idle(6);

    // NaN / zero corners and sign-inject, spaced out.
    drive(1, 1, 32'h7fc00001, 32'h3f800000);
    drive(1, 0, 32'h7fc00001, 32'hff800001);
    drive(1, 0, 32'h00000000, 32'h80000000);
    drive(1, 3, 32'h80000000, 32'h00000000);
    drive(1, 3, 32'h7fc00000, 32'h3f800000);
    drive(1, 3, 32'h3f800000, 32'h40000000);
    drive(1, 2, 32'h7f812345, 32'h80000000);
    idle(6);

    // Reset mid-flight; a request held during reset must be ignored.
    drive(1, 0, 32'h3f800000, 32'h40000000);
    drive(1, 1, 32'h3f800000, 32'h40000000);
    rst = 1'b1; d_trig = 1'b1; d_mode = 1; d_lhs = 32'h40400000; d_rhs = 0;
    #1;
    chk("d_ready in rst", {31'b0, rdy_a[1]}, 32'h0);
    @(negedge clk);
    chk("inflight after rst", inf_a[3], 0);
    rst = 1'b0;
    drive(1, 0, 32'hc0000000, 32'h3f800000);
    idle(7);

    // Random traffic from a corner-heavy pool, occasional reset.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 2) != 0, 2'($urandom),
            $urandom_range(0, 3) == 0 ? $urandom : pool[$urandom_range(0, 11)],
            $urandom_range(0, 3) == 0 ? $urandom : pool[$urandom_range(0, 11)]);
    end
    rst = 1'b0;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
